// File: rtl/l2_port_arbiter_if.sv
// Bundles the two L1 requester ports and the shared L2 port of l2_port_arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface l2_port_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int L1_BLOCK_SIZE = 16
);
  logic [ADDR_WIDTH-1:0]                      p0_addr, p1_addr;
  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]   p0_data_in, p1_data_in;
  logic                                       p0_read, p1_read;
  logic                                       p0_write, p1_write;
  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]   p0_data_out, p1_data_out;
  logic                                       p0_ready, p1_ready;
  logic                                       p0_hit, p1_hit;
  logic [ADDR_WIDTH-1:0]                      l2_cache_addr;
  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]   l2_cache_data_in;
  logic                                       l2_cache_read, l2_cache_write;
  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]   l2_cache_data_out;
  logic                                       l2_cache_ready;
  logic                                       l2_hit;
  logic                                       arb_busy;

  modport slave (
    input  p0_addr, p1_addr, p0_data_in, p1_data_in,
           p0_read, p1_read, p0_write, p1_write,
           l2_cache_data_out, l2_cache_ready, l2_hit,
    output p0_data_out, p1_data_out, p0_ready, p1_ready, p0_hit, p1_hit,
           l2_cache_addr, l2_cache_data_in, l2_cache_read, l2_cache_write,
           arb_busy
  );

  modport master (
    output p0_addr, p1_addr, p0_data_in, p1_data_in,
           p0_read, p1_read, p0_write, p1_write,
           l2_cache_data_out, l2_cache_ready, l2_hit,
    input  p0_data_out, p1_data_out, p0_ready, p1_ready, p0_hit, p1_hit,
           l2_cache_addr, l2_cache_data_in, l2_cache_read, l2_cache_write,
           arb_busy
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// Two-requester (I-side p0, D-side p1) arbiter for the single L2 request port.
// Define L2_ARB_FIXED_PRIORITY_EN to make p1 win every tie; default is round-robin.
module l2_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int L1_BLOCK_SIZE = 16
) (
  input logic clk,
  input logic rst_n,
  l2_port_arbiter_if.slave bus
);
  typedef logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t                r_state, w_next;
  logic                  w_p0_req, w_p1_req, w_grant, w_sel, w_tie_sel;
  logic                  w_sel_rd, w_sel_wr;
  logic                  r_gnt;
  logic [ADDR_WIDTH-1:0] r_l2_addr;
  block_t                r_l2_data, r_p0_data, r_p1_data;
  logic                  r_l2_rd, r_l2_wr;
  logic                  r_p0_ready, r_p1_ready, r_p0_hit, r_p1_hit, r_busy;

  assign w_p0_req = bus.p0_read | bus.p0_write;
  assign w_p1_req = bus.p1_read | bus.p1_write;

`ifdef L2_ARB_FIXED_PRIORITY_EN
  assign w_tie_sel = 1'b1;
`else
  logic r_last_gnt;

  // On a tie the port that did not win last time is served.
  assign w_tie_sel = ~r_last_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last_gnt <= 1'b1;
    else if (w_grant) r_last_gnt <= w_sel;
  end
`endif

  // A write wins over a read raised on the same port.
  assign w_sel_wr = w_sel ? bus.p1_write : bus.p0_write;
  assign w_sel_rd = w_sel ? (bus.p1_read & ~bus.p1_write) : (bus.p0_read & ~bus.p0_write);

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_sel   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_p0_req | w_p1_req) begin
          w_grant = 1'b1;
          w_sel   = (w_p0_req & w_p1_req) ? w_tie_sel : w_p1_req;
          w_next  = BUSY;
        end
      end
      BUSY:    if (bus.l2_cache_ready) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= 1'b0;
      r_l2_addr  <= '0;
      r_l2_data  <= '0;
      r_l2_rd    <= 1'b0;
      r_l2_wr    <= 1'b0;
      r_p0_data  <= '0;
      r_p1_data  <= '0;
      r_p0_hit   <= 1'b0;
      r_p1_hit   <= 1'b0;
      r_p0_ready <= 1'b0;
      r_p1_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_p0_ready <= 1'b0;
      r_p1_ready <= 1'b0;
      if (w_grant) begin
        r_gnt     <= w_sel;
        r_l2_addr <= w_sel ? bus.p1_addr : bus.p0_addr;
        r_l2_data <= w_sel ? bus.p1_data_in : bus.p0_data_in;
        r_l2_rd   <= w_sel_rd;
        r_l2_wr   <= w_sel_wr;
        r_busy    <= 1'b1;
      end
      // The ready pulse lands in RESP; only the granted port's response registers move.
      if (r_state == BUSY && bus.l2_cache_ready) begin
        r_l2_rd <= 1'b0;
        r_l2_wr <= 1'b0;
        if (r_gnt) begin
          r_p1_data  <= bus.l2_cache_data_out;
          r_p1_hit   <= bus.l2_hit;
          r_p1_ready <= 1'b1;
        end else begin
          r_p0_data  <= bus.l2_cache_data_out;
          r_p0_hit   <= bus.l2_hit;
          r_p0_ready <= 1'b1;
        end
      end
      if (r_state == RESP) r_busy <= 1'b0;
    end
  end

  assign bus.l2_cache_addr    = r_l2_addr;
  assign bus.l2_cache_data_in = r_l2_data;
  assign bus.l2_cache_read    = r_l2_rd;
  assign bus.l2_cache_write   = r_l2_wr;
  assign bus.p0_data_out      = r_p0_data;
  assign bus.p1_data_out      = r_p1_data;
  assign bus.p0_hit           = r_p0_hit;
  assign bus.p1_hit           = r_p1_hit;
  assign bus.p0_ready         = r_p0_ready;
  assign bus.p1_ready         = r_p1_ready;
  assign bus.arb_busy         = r_busy;
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: directed requests, an L2 responder model and
// a monitor that checks every L2 request and every requester response against queues.
module tb_l2_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BS = 16;
  typedef logic [BS-1:0][DW-1:0] block_t;

  typedef struct {logic [AW-1:0] addr; logic rd; logic wr; block_t wdata; int lat;} l2_exp_t;
  typedef struct {int port; block_t data; logic hit;} resp_t;
  typedef struct {block_t data; logic hit; int lat;} l2_rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic l2_rdy_resp = 1'b0;
  logic l2_rdy_spur = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  l2_exp_t exp_l2[$];
  resp_t   exp_resp[$];
  l2_rsp_t l2_rsp[$];

  always #5 clk = ~clk;

  l2_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .L1_BLOCK_SIZE(BS)) bus ();

  l2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .L1_BLOCK_SIZE(BS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.l2_cache_ready = l2_rdy_resp | l2_rdy_spur;

  function automatic block_t mk_block(input logic [31:0] base);
    block_t b;
    for (int i = 0; i < BS; i++) b[i] = base ^ 32'(i);
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_blk(input string name, input block_t got, input block_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expect_txn(input int port, input logic [AW-1:0] addr, input logic rd,
                            input logic wr, input block_t wdata, input int lat,
                            input block_t rdata, input logic hit, input bit completes);
    l2_exp_t e;
    l2_rsp_t r;
    resp_t   p;
    e.addr = addr; e.rd = rd; e.wr = wr; e.wdata = wdata; e.lat = lat;
    r.data = rdata; r.hit = hit; r.lat = lat;
    p.port = port; p.data = rdata; p.hit = hit;
    exp_l2.push_back(e);
    l2_rsp.push_back(r);
    if (completes) exp_resp.push_back(p);
  endtask

  task automatic issue(input int port, input logic rd, input logic wr,
                       input logic [AW-1:0] addr, input block_t d);
    if (port == 0) begin
      bus.p0_read = rd; bus.p0_write = wr; bus.p0_addr = addr; bus.p0_data_in = d;
    end else begin
      bus.p1_read = rd; bus.p1_write = wr; bus.p1_addr = addr; bus.p1_data_in = d;
    end
  endtask

  task automatic wait_done(input string name, input int budget, input bit withdraw);
    int  i;
    bit  pend;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.p0_ready || bus.p1_ready) begin
        if (bus.p0_ready || withdraw) begin bus.p0_read = 1'b0; bus.p0_write = 1'b0; end
        if (bus.p1_ready || withdraw) begin bus.p1_read = 1'b0; bus.p1_write = 1'b0; end
      end
      pend = bus.p0_read | bus.p0_write | bus.p1_read | bus.p1_write;
      if (!pend && !bus.arb_busy && exp_resp.size() == 0) break;
    end
    if (i == budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d cycles, expected completion within %0d", name, i, budget);
      bus.p0_read = 1'b0; bus.p0_write = 1'b0; bus.p1_read = 1'b0; bus.p1_write = 1'b0;
    end
  endtask

  // L2 model: raises ready once the opcode has been visible for 'lat' cycles.
  initial begin
    int      cnt;
    l2_rsp_t cur;
    cnt = 0;
    cur.data = '0; cur.hit = 1'b0; cur.lat = 1;
    bus.l2_cache_data_out = '0;
    bus.l2_hit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cnt = 0;
        l2_rdy_resp = 1'b0;
      end else if (l2_rdy_resp) begin
        l2_rdy_resp = 1'b0;
        cnt = 0;
      end else if (bus.l2_cache_read || bus.l2_cache_write) begin
        if (cnt == 0) begin
          if (l2_rsp.size() > 0) cur = l2_rsp.pop_front();
          else begin cur.data = '0; cur.hit = 1'b0; cur.lat = 1; end
        end
        cnt++;
        if (cnt >= cur.lat) begin
          l2_rdy_resp = 1'b1;
          bus.l2_cache_data_out = cur.data;
          bus.l2_hit = cur.hit;
        end
      end
    end
  end

  // Monitor: checks L2 requests, their duration, and every requester response.
  initial begin
    logic    prev_op;
    logic    op;
    int      opc;
    l2_exp_t ce;
    resp_t   cr;
    prev_op = 1'b0;
    opc = 0;
    ce.addr = '0; ce.rd = 1'b0; ce.wr = 1'b0; ce.wdata = '0; ce.lat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_op = 1'b0;
        opc = 0;
      end else begin
        op = bus.l2_cache_read | bus.l2_cache_write;
        if (op && !prev_op) begin
          opc = 1;
          if (exp_l2.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL l2_unexpected_req: got addr 0x%0h, expected no request", bus.l2_cache_addr);
          end else begin
            ce = exp_l2.pop_front();
            check("l2_addr", 64'(bus.l2_cache_addr), 64'(ce.addr));
            check("l2_read", 64'(bus.l2_cache_read), 64'(ce.rd));
            check("l2_write", 64'(bus.l2_cache_write), 64'(ce.wr));
            check_blk("l2_data_in", bus.l2_cache_data_in, ce.wdata);
          end
        end else if (op) begin
          opc++;
          check("l2_addr_stable", 64'(bus.l2_cache_addr), 64'(ce.addr));
        end else if (prev_op) begin
          check("l2_op_cycles", 64'(opc), 64'(ce.lat));
        end
        prev_op = op;
        if (bus.p0_ready && bus.p1_ready) begin
          n_tests++;
          n_fail++;
          $display("FAIL both_ready: got p0_ready=1 p1_ready=1, expected at most one");
        end
        if (bus.p0_ready || bus.p1_ready) begin
          if (exp_resp.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: got p0=%0b p1=%0b, expected none", bus.p0_ready, bus.p1_ready);
          end else begin
            cr = exp_resp.pop_front();
            check("resp_port", 64'(bus.p1_ready ? 1 : 0), 64'(cr.port));
            if (bus.p1_ready) begin
              check_blk("p1_data_out", bus.p1_data_out, cr.data);
              check("p1_hit", 64'(bus.p1_hit), 64'(cr.hit));
            end else begin
              check_blk("p0_data_out", bus.p0_data_out, cr.data);
              check("p0_hit", 64'(bus.p0_hit), 64'(cr.hit));
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int win[3];
    bus.p0_read = 1'b0; bus.p0_write = 1'b0; bus.p0_addr = '0; bus.p0_data_in = '0;
    bus.p1_read = 1'b0; bus.p1_write = 1'b0; bus.p1_addr = '0; bus.p1_data_in = '0;
`ifdef L2_ARB_FIXED_PRIORITY_EN
    win = '{1, 1, 1};
`else
    win = '{1, 0, 1};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_p0_ready", 64'(bus.p0_ready), 64'd0);
    check("rst_p1_ready", 64'(bus.p1_ready), 64'd0);
    check("rst_hits", 64'({bus.p0_hit, bus.p1_hit}), 64'd0);
    check_blk("rst_p0_data", bus.p0_data_out, '0);
    check_blk("rst_p1_data", bus.p1_data_out, '0);
    check("rst_l2_op", 64'({bus.l2_cache_read, bus.l2_cache_write}), 64'd0);
    check("rst_l2_addr", 64'(bus.l2_cache_addr), 64'd0);
    check_blk("rst_l2_data_in", bus.l2_cache_data_in, '0);
    check("rst_busy", 64'(bus.arb_busy), 64'd0);
    rst_n = 1'b1;

    // Tie right after reset: p0 first under round-robin, p1 first with fixed priority.
`ifdef L2_ARB_FIXED_PRIORITY_EN
    expect_txn(1, 32'h200, 1'b0, 1'b1, mk_block(32'hA5A5A5A5), 2, mk_block(32'h22220000), 1'b0, 1'b1);
    expect_txn(0, 32'h100, 1'b1, 1'b0, mk_block(32'h0D0D0000), 1, mk_block(32'h11110000), 1'b1, 1'b1);
`else
    expect_txn(0, 32'h100, 1'b1, 1'b0, mk_block(32'h0D0D0000), 1, mk_block(32'h11110000), 1'b1, 1'b1);
    expect_txn(1, 32'h200, 1'b0, 1'b1, mk_block(32'hA5A5A5A5), 2, mk_block(32'h22220000), 1'b0, 1'b1);
`endif
    issue(0, 1'b1, 1'b0, 32'h100, mk_block(32'h0D0D0000));
    issue(1, 1'b0, 1'b1, 32'h200, mk_block(32'hA5A5A5A5));
    wait_done("tie_pair", 40, 1'b0);

    // Single p0 read with three L2 wait cycles.
    expect_txn(0, 32'h100, 1'b1, 1'b0, mk_block(32'h0D0D0000), 3, mk_block(32'hDEADBEEF), 1'b0, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h100, mk_block(32'h0D0D0000));
    wait_done("single_read", 40, 1'b0);
    check("p0_word0_held", 64'(bus.p0_data_out[0]), 64'h0000_0000_DEAD_BEEF);

    // Repeated ties where the loser withdraws after the winner completes.
    for (int k = 0; k < 3; k++) begin
      expect_txn(win[k], (win[k] == 1) ? 32'(32'h600 + k) : 32'(32'h500 + k), 1'b1, 1'b0,
                 mk_block(32'h0E0E0000), 1, mk_block(32'h30300000 + 32'(k)), 1'(k), 1'b1);
      issue(0, 1'b1, 1'b0, 32'(32'h500 + k), mk_block(32'h0E0E0000));
      issue(1, 1'b1, 1'b0, 32'(32'h600 + k), mk_block(32'h0E0E0000));
      wait_done("tie_round", 40, 1'b1);
    end

    // Read and write together on p1: the L2 sees only the write, data unchanged.
    expect_txn(1, 32'h300, 1'b0, 1'b1, mk_block(32'h5A5A0000), 2, mk_block(32'h44440000), 1'b1, 1'b1);
    issue(1, 1'b1, 1'b1, 32'h300, mk_block(32'h5A5A0000));
    wait_done("rw_both", 40, 1'b0);

    // Spurious L2 ready while idle.
    @(posedge clk);
    #1;
    l2_rdy_spur = 1'b1;
    @(posedge clk);
    #1;
    l2_rdy_spur = 1'b0;
    check("spur_busy", 64'(bus.arb_busy), 64'd0);
    check("spur_ready", 64'({bus.p0_ready, bus.p1_ready}), 64'd0);
    @(posedge clk);
    #1;
    check("spur_ready_next", 64'({bus.p0_ready, bus.p1_ready, bus.arb_busy}), 64'd0);
    check("spur_l2_op", 64'({bus.l2_cache_read, bus.l2_cache_write}), 64'd0);

    // Reset in the middle of a long BUSY: the in-flight response is dropped.
    expect_txn(0, 32'h380, 1'b1, 1'b0, mk_block(32'h0F0F0000), 10, mk_block(32'h55550000), 1'b1, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h380, mk_block(32'h0F0F0000));
    repeat (3) @(posedge clk);
    #2;
    check("busy_before_rst", 64'({bus.arb_busy, bus.l2_cache_read}), 64'h3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_l2_read", 64'(bus.l2_cache_read), 64'd0);
    check("rst_mid_l2_addr", 64'(bus.l2_cache_addr), 64'd0);
    check("rst_mid_busy", 64'(bus.arb_busy), 64'd0);
    check_blk("rst_mid_p0_data", bus.p0_data_out, '0);
    check_blk("rst_mid_p1_data", bus.p1_data_out, '0);
    check("rst_mid_hits", 64'({bus.p0_hit, bus.p1_hit, bus.p0_ready, bus.p1_ready}), 64'd0);
    issue(0, 1'b0, 1'b0, 32'h0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 64'({bus.arb_busy, bus.l2_cache_read, bus.l2_cache_write}), 64'd0);

    expect_txn(0, 32'h400, 1'b1, 1'b0, mk_block(32'h0A0A0000), 1, mk_block(32'h66660000), 1'b1, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h400, mk_block(32'h0A0A0000));
    wait_done("post_rst_read", 40, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("exp_l2_drained", 64'(exp_l2.size()), 64'd0);
    check("exp_resp_drained", 64'(exp_resp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
